// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encodings and line levels shared by transmitter and receiver
package uart_pkg;
    localparam int   UART_DATA_W      = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake between a producer and the UART transmitter
interface uart_tx_if;
    import uart_pkg::*;
    logic [UART_DATA_W-1:0] tx_byte;
    logic                   tx_valid;
    logic                   tx_ready;

    modport master (output tx_byte, output tx_valid, input tx_ready);
    modport slave  (input tx_byte, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO feeding the UART transmitter
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-buffered 8N1 UART transmitter; UART_TX_PARITY_EN adds an even parity bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        res_n,
    uart_tx_if.slave    tx_if,
    output logic        tx,
    output logic        busy,
    output logic        tx_done
);
    localparam int CW = $clog2(OVERSAMPLE);

    uart_state_e            state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif
    logic                   cnt_wrap;
    logic                   fifo_pop, fifo_full, fifo_empty;
    logic [UART_DATA_W-1:0] fifo_dout;

    assign tx_if.tx_ready = !fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .res_n (res_n),
        .push  (tx_if.tx_valid && !fifo_full),
        .din   (tx_if.tx_byte),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        tx_d     = UART_IDLE_LEVEL;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        cnt_wrap = (cnt_q == CW'(OVERSAMPLE - 1));
        busy_d   = (state_q != ST_IDLE) || !fifo_empty;
        if (state_q != ST_IDLE) begin
            cnt_d = cnt_wrap ? '0 : cnt_q + CW'(1);
        end
        // tx_d reflects the current state, so the line lags the FSM by one clock.
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_dout);
`endif
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                tx_d = UART_START_LEVEL;
                if (cnt_wrap) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (cnt_wrap) begin
                    shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = parity_q;
                if (cnt_wrap) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                tx_d = UART_STOP_LEVEL;
                if (cnt_wrap) begin
                    done_d = 1'b1;
                    // Chain straight into the next frame without an idle bit.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_d = even_parity(fifo_dout);
`endif
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= UART_IDLE_LEVEL;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;
    localparam int OS    = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F    = (10 + PAR) * OS;
    localparam int MAXC = 16384;

    logic clk = 1'b0;
    logic res_n;
    logic tx, busy, tx_done;

    uart_tx_if u_if ();

    uart_tx #(
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .res_n   (res_n),
        .tx_if   (u_if),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    logic tx_log [MAXC];
    logic done_log [MAXC];
    logic busy_log [MAXC];
    logic ready_log [MAXC];

    int         pu_q [$];
    int         st_q [$];
    logic [7:0] dat_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            tx_log[cyc]    <= tx;
            done_log[cyc]  <= tx_done;
            busy_log[cyc]  <= busy;
            ready_log[cyc] <= u_if.tx_ready;
        end
    end

    // Reference: byte i is pushed at edge p, its frame occupies samples [s, s+F).
    function automatic logic [3:0] exp_vec(int n);
        logic t = 1'b1;
        logic d = 1'b0;
        logic b = 1'b0;
        int occ = 0;
        for (int i = 0; i < st_q.size(); i++) begin
            int s = st_q[i];
            int p = pu_q[i];
            int pos;
            logic [7:0] v = dat_q[i];
            if (n >= s && n < s + F) begin
                pos = (n - s) / OS;
                if (pos == 0) t = 1'b0;
                else if (pos <= 8) t = v[pos-1];
                else if (pos == 9 && PAR == 1) t = ^v;
                else t = 1'b1;
                d = (n == s + F - 1);
            end
            if (n >= p + 1 && n < s + F) b = 1'b1;
            if (n >= p && n <= s - 2) occ++;
        end
        return {t, d, b, (occ < DEPTH)};
    endfunction

    function automatic bit model_ready(int n);
        logic [3:0] v = exp_vec(n);
        return v[0];
    endfunction

    task automatic model_accept(input logic [7:0] b);
        int p = cyc + 1;
        int s = p + 2;
        if (st_q.size() > 0 && st_q[st_q.size()-1] + F > s) s = st_q[st_q.size()-1] + F;
        pu_q.push_back(p);
        st_q.push_back(s);
        dat_q.push_back(b);
    endtask

    function automatic int count_done(int a, int b);
        int c = 0;
        for (int n = a; n < b; n++) if (done_log[n] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_low(int a, int b);
        for (int n = a; n < b; n++) if (tx_log[n] === 1'b0) return n;
        return -1;
    endfunction

    function automatic int last_done(int a, int b);
        int r = -1;
        for (int n = a; n < b; n++) if (done_log[n] === 1'b1) r = n;
        return r;
    endfunction

    task automatic do_reset();
        res_n = 1'b0;
        u_if.tx_valid = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        pu_q.delete();
        st_q.delete();
        dat_q.delete();
        t0 = cyc;
    endtask

    task automatic push_byte(input logic [7:0] b, output int first_try);
        u_if.tx_valid = 1'b1;
        u_if.tx_byte  = b;
        first_try = cyc;
        for (int k = 0; k < 400; k++) begin
            if (model_ready(cyc)) begin
                model_accept(b);
                @(negedge clk);
                u_if.tx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        u_if.tx_valid = 1'b0;
    endtask

    task automatic drain();
        int e = (st_q.size() > 0) ? st_q[st_q.size()-1] + F + 3 : cyc + 3;
        while (cyc < e) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        @(negedge clk);
        total++; if (tx_log[t0] !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx_log[t0]); end
        total++; if (busy_log[t0] !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_log[t0]); end
        total++; if (ready_log[t0] !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_log[t0]); end
        total++; if (done_log[t0] !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_log[t0]); end
    endtask

    task automatic test_idle();
        int errs = 0, fn = 0;
        logic [3:0] av, ev, fa, fe;
        do_reset();
        repeat (100) @(negedge clk);
        for (int n = t0; n < cyc; n++) begin
            ev = exp_vec(n); av = {tx_log[n], done_log[n], busy_log[n], ready_log[n]};
            if (av !== ev) begin if (errs == 0) begin fn = n; fa = av; fe = ev; end errs++; end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL idle_wave: cycle %0d got %b want %b (%0d cycles)", fn, fa, fe, errs); end
        total++; if (count_done(t0, cyc) !== 0) begin bad++; $display("FAIL idle_done: got %0d pulses want 0", count_done(t0, cyc)); end
    endtask

    task automatic test_single();
        int errs = 0, fn = 0, ft, fl, ld;
        logic [3:0] av, ev, fa, fe;
        do_reset();
        push_byte(8'h55, ft);
        drain();
        for (int n = t0; n < cyc; n++) begin
            ev = exp_vec(n); av = {tx_log[n], done_log[n], busy_log[n], ready_log[n]};
            if (av !== ev) begin if (errs == 0) begin fn = n; fa = av; fe = ev; end errs++; end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL single_wave: cycle %0d got %b want %b (%0d cycles)", fn, fa, fe, errs); end
        total++; if (count_done(t0, cyc) !== 1) begin bad++; $display("FAIL single_done: got %0d pulses want 1", count_done(t0, cyc)); end
        fl = first_low(t0, cyc); ld = last_done(t0, cyc);
        total++; if (ld - fl + 1 !== F) begin bad++; $display("FAIL single_len: got %0d clks want %0d", ld - fl + 1, F); end
        total++; if (fl !== ft + 3) begin bad++; $display("FAIL single_latency: start at %0d want %0d", fl, ft + 3); end
    endtask

    task automatic test_back_to_back();
        int errs = 0, fn = 0, ft, ft_last, fl, ld;
        logic [3:0] av, ev, fa, fe;
        do_reset();
        for (int b = 1; b <= 6; b++) begin
            push_byte(8'(b), ft);
            if (b == 6) ft_last = ft;
        end
        drain();
        for (int n = t0; n < cyc; n++) begin
            ev = exp_vec(n); av = {tx_log[n], done_log[n], busy_log[n], ready_log[n]};
            if (av !== ev) begin if (errs == 0) begin fn = n; fa = av; fe = ev; end errs++; end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL b2b_wave: cycle %0d got %b want %b (%0d cycles)", fn, fa, fe, errs); end
        total++; if (ready_log[ft_last] !== 1'b0) begin bad++; $display("FAIL b2b_stall: tx_ready got %b want 0", ready_log[ft_last]); end
        total++; if (count_done(t0, cyc) !== 6) begin bad++; $display("FAIL b2b_done: got %0d pulses want 6", count_done(t0, cyc)); end
        fl = first_low(t0, cyc); ld = last_done(t0, cyc);
        total++; if (ld - fl + 1 !== 6 * F) begin bad++; $display("FAIL b2b_span: got %0d clks want %0d", ld - fl + 1, 6 * F); end
        total++; if (busy_log[ld + 1] !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b want 0", busy_log[ld + 1]); end
    endtask

    task automatic test_abort();
        int errs = 0, fn = 0, ft, r;
        logic [3:0] av, ev, fa, fe;
        do_reset();
        push_byte(8'hA3, ft);
        push_byte(8'($urandom), ft);
        push_byte(8'($urandom), ft);
        while (cyc < st_q[0] + 3 * OS + 1) @(negedge clk);
        for (int n = t0; n < cyc; n++) begin
            ev = exp_vec(n); av = {tx_log[n], done_log[n], busy_log[n], ready_log[n]};
            if (av !== ev) begin if (errs == 0) begin fn = n; fa = av; fe = ev; end errs++; end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL abort_pre_wave: cycle %0d got %b want %b (%0d cycles)", fn, fa, fe, errs); end
        do_reset();
        r = t0;
        repeat (100) @(negedge clk);
        total++; if (tx_log[r] !== 1'b1) begin bad++; $display("FAIL abort_tx: got %b want 1", tx_log[r]); end
        total++; if (busy_log[r] !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy_log[r]); end
        total++; if (ready_log[r] !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", ready_log[r]); end
        errs = 0;
        for (int n = r; n < cyc; n++) begin
            ev = exp_vec(n); av = {tx_log[n], done_log[n], busy_log[n], ready_log[n]};
            if (av !== ev) begin if (errs == 0) begin fn = n; fa = av; fe = ev; end errs++; end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL abort_post_wave: cycle %0d got %b want %b (%0d cycles)", fn, fa, fe, errs); end
    endtask

    task automatic test_stall();
        int errs = 0, fn = 0;
        logic [3:0] av, ev, fa, fe;
        logic [7:0] b;
        do_reset();
        for (int k = 0; k < 120; k++) begin
            b = 8'($urandom);
            u_if.tx_valid = 1'b1;
            u_if.tx_byte  = b;
            if (model_ready(cyc)) model_accept(b);
            @(negedge clk);
        end
        u_if.tx_valid = 1'b0;
        drain();
        for (int n = t0; n < cyc; n++) begin
            ev = exp_vec(n); av = {tx_log[n], done_log[n], busy_log[n], ready_log[n]};
            if (av !== ev) begin if (errs == 0) begin fn = n; fa = av; fe = ev; end errs++; end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL stall_wave: cycle %0d got %b want %b (%0d cycles)", fn, fa, fe, errs); end
        total++; if (count_done(t0, cyc) !== st_q.size()) begin bad++; $display("FAIL stall_done: got %0d pulses want %0d", count_done(t0, cyc), st_q.size()); end
    endtask

    task automatic test_random();
        int errs = 0, fn = 0, ft;
        logic [3:0] av, ev, fa, fe;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            push_byte(8'($urandom), ft);
        end
        drain();
        for (int n = t0; n < cyc; n++) begin
            ev = exp_vec(n); av = {tx_log[n], done_log[n], busy_log[n], ready_log[n]};
            if (av !== ev) begin if (errs == 0) begin fn = n; fa = av; fe = ev; end errs++; end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL random_wave: cycle %0d got %b want %b (%0d cycles)", fn, fa, fe, errs); end
        total++; if (count_done(t0, cyc) !== 8) begin bad++; $display("FAIL random_done: got %0d pulses want 8", count_done(t0, cyc)); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int ft, fl, ld, s0, s1;
        do_reset();
        push_byte(8'h07, ft);
        push_byte(8'h03, ft);
        drain();
        fl = first_low(t0, cyc);
        s0 = fl;
        s1 = fl + F;
        total++; if (tx_log[s0 + 9 * OS] !== 1'b1) begin bad++; $display("FAIL parity_07: got %b want 1", tx_log[s0 + 9 * OS]); end
        total++; if (tx_log[s1 + 9 * OS] !== 1'b0) begin bad++; $display("FAIL parity_03: got %b want 0", tx_log[s1 + 9 * OS]); end
        ld = last_done(t0, s1);
        total++; if (ld - fl + 1 !== 11 * OS) begin bad++; $display("FAIL parity_len: got %0d clks want %0d", ld - fl + 1, 11 * OS); end
    endtask
`endif

    initial begin
        res_n = 1'b0;
        u_if.tx_valid = 1'b0;
        u_if.tx_byte  = 8'h00;
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_abort();
        test_stall();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
